// File: rtl/csr_file.sv
// Machine-mode CSR file: three writeback write ports, one combinational read port.
// Latency: writes land at the rising edge of the strobe cycle; reads are combinational with no bypass.
// Backpressure: none, because every strobe is accepted in the cycle it is presented.
//
// Ports:
//   clk, rst                     clock and async active-high reset
//   wr_en*/wr_addr*/wr_data*     write ports 0..2 (port 2 has the highest priority)
//   commit_valid                 one instruction retired this cycle (minstret)
//   rd_addr -> rd_data           combinational read; rd_illegal flags unimplemented addresses
//   mstatus_o/mtvec_o/mepc_o/satp_o  live register contents
module csr_file #(
    parameter logic [63:0] MHARTID = 64'd0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_en0,
    input  logic        wr_en1,
    input  logic        wr_en2,
    input  logic [11:0] wr_addr0,
    input  logic [11:0] wr_addr1,
    input  logic [11:0] wr_addr2,
    input  logic [63:0] wr_data0,
    input  logic [63:0] wr_data1,
    input  logic [63:0] wr_data2,
    input  logic        commit_valid,
    input  logic [11:0] rd_addr,
    output logic [63:0] rd_data,
    output logic        rd_illegal,
    output logic [63:0] mstatus_o,
    output logic [63:0] mtvec_o,
    output logic [63:0] mepc_o,
    output logic [63:0] satp_o
);
    localparam logic [11:0] A_SATP     = 12'h180;
    localparam logic [11:0] A_MSTATUS  = 12'h300;
    localparam logic [11:0] A_MISA     = 12'h301;
    localparam logic [11:0] A_MIE      = 12'h304;
    localparam logic [11:0] A_MTVEC    = 12'h305;
    localparam logic [11:0] A_MSCRATCH = 12'h340;
    localparam logic [11:0] A_MEPC     = 12'h341;
    localparam logic [11:0] A_MCAUSE   = 12'h342;
    localparam logic [11:0] A_MTVAL    = 12'h343;
    localparam logic [11:0] A_MIP      = 12'h344;
    localparam logic [11:0] A_MCYCLE   = 12'hB00;
    localparam logic [11:0] A_MINSTRET = 12'hB02;
    localparam logic [11:0] A_MHARTID  = 12'hF14;

    localparam logic [63:0] MISA_VAL     = 64'h8000_0000_0000_1100;
    localparam logic [63:0] MSTATUS_MASK = 64'h0000_0000_0006_1888;
    localparam logic [63:0] IRQ_MASK     = 64'h0000_0000_0000_0AAA;

    logic [63:0] r_satp, r_mstatus, r_mie, r_mtvec, r_mscratch, r_mepc;
    logic [63:0] r_mcause, r_mtval, r_mip, r_mcycle, r_minstret;

    // Resolve the three ports for one address: {hit, data}. Later ports
    // overwrite earlier ones so port 2 wins on a same-address collision.
    function automatic logic [64:0] f_wsel(
        input logic [11:0] a,
        input logic        e0, input logic [11:0] a0, input logic [63:0] d0,
        input logic        e1, input logic [11:0] a1, input logic [63:0] d1,
        input logic        e2, input logic [11:0] a2, input logic [63:0] d2
    );
        f_wsel = '0;
        if (e0 && a0 == a) f_wsel = {1'b1, d0};
        if (e1 && a1 == a) f_wsel = {1'b1, d1};
        if (e2 && a2 == a) f_wsel = {1'b1, d2};
    endfunction

    logic [64:0] w_satp, w_mstatus, w_mie, w_mtvec, w_mscratch, w_mepc;
    logic [64:0] w_mcause, w_mtval, w_mip, w_mcycle, w_minstret;

    assign w_satp     = f_wsel(A_SATP,     wr_en0, wr_addr0, wr_data0, wr_en1, wr_addr1, wr_data1, wr_en2, wr_addr2, wr_data2);
    assign w_mstatus  = f_wsel(A_MSTATUS,  wr_en0, wr_addr0, wr_data0, wr_en1, wr_addr1, wr_data1, wr_en2, wr_addr2, wr_data2);
    assign w_mie      = f_wsel(A_MIE,      wr_en0, wr_addr0, wr_data0, wr_en1, wr_addr1, wr_data1, wr_en2, wr_addr2, wr_data2);
    assign w_mtvec    = f_wsel(A_MTVEC,    wr_en0, wr_addr0, wr_data0, wr_en1, wr_addr1, wr_data1, wr_en2, wr_addr2, wr_data2);
    assign w_mscratch = f_wsel(A_MSCRATCH, wr_en0, wr_addr0, wr_data0, wr_en1, wr_addr1, wr_data1, wr_en2, wr_addr2, wr_data2);
    assign w_mepc     = f_wsel(A_MEPC,     wr_en0, wr_addr0, wr_data0, wr_en1, wr_addr1, wr_data1, wr_en2, wr_addr2, wr_data2);
    assign w_mcause   = f_wsel(A_MCAUSE,   wr_en0, wr_addr0, wr_data0, wr_en1, wr_addr1, wr_data1, wr_en2, wr_addr2, wr_data2);
    assign w_mtval    = f_wsel(A_MTVAL,    wr_en0, wr_addr0, wr_data0, wr_en1, wr_addr1, wr_data1, wr_en2, wr_addr2, wr_data2);
    assign w_mip      = f_wsel(A_MIP,      wr_en0, wr_addr0, wr_data0, wr_en1, wr_addr1, wr_data1, wr_en2, wr_addr2, wr_data2);
    assign w_mcycle   = f_wsel(A_MCYCLE,   wr_en0, wr_addr0, wr_data0, wr_en1, wr_addr1, wr_data1, wr_en2, wr_addr2, wr_data2);
    assign w_minstret = f_wsel(A_MINSTRET, wr_en0, wr_addr0, wr_data0, wr_en1, wr_addr1, wr_data1, wr_en2, wr_addr2, wr_data2);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_satp     <= '0;
            r_mstatus  <= '0;
            r_mie      <= '0;
            r_mtvec    <= '0;
            r_mscratch <= '0;
            r_mepc     <= '0;
            r_mcause   <= '0;
            r_mtval    <= '0;
            r_mip      <= '0;
            r_mcycle   <= '0;
            r_minstret <= '0;
        end else begin
            if (w_satp[64])     r_satp     <= w_satp[63:0];
            if (w_mstatus[64])  r_mstatus  <= (r_mstatus & ~MSTATUS_MASK) | (w_mstatus[63:0] & MSTATUS_MASK);
            if (w_mie[64])      r_mie      <= (r_mie & ~IRQ_MASK) | (w_mie[63:0] & IRQ_MASK);
            if (w_mip[64])      r_mip      <= (r_mip & ~IRQ_MASK) | (w_mip[63:0] & IRQ_MASK);
            // mtvec bit 1 is reserved in the mode field; mepc is always 4-byte aligned.
            if (w_mtvec[64])    r_mtvec    <= w_mtvec[63:0] & ~64'h2;
            if (w_mepc[64])     r_mepc     <= w_mepc[63:0] & ~64'h3;
            if (w_mscratch[64]) r_mscratch <= w_mscratch[63:0];
            if (w_mcause[64])   r_mcause   <= w_mcause[63:0];
            if (w_mtval[64])    r_mtval    <= w_mtval[63:0];
            // A software write replaces the count for that cycle; the increment is dropped.
            r_mcycle <= w_mcycle[64] ? w_mcycle[63:0] : r_mcycle + 64'd1;
            if (w_minstret[64])    r_minstret <= w_minstret[63:0];
            else if (commit_valid) r_minstret <= r_minstret + 64'd1;
        end
    end

    always_comb begin
        rd_data    = '0;
        rd_illegal = 1'b0;
        case (rd_addr)
            A_SATP:     rd_data = r_satp;
            A_MSTATUS:  rd_data = r_mstatus;
            A_MISA:     rd_data = MISA_VAL;
            A_MIE:      rd_data = r_mie;
            A_MTVEC:    rd_data = r_mtvec;
            A_MSCRATCH: rd_data = r_mscratch;
            A_MEPC:     rd_data = r_mepc;
            A_MCAUSE:   rd_data = r_mcause;
            A_MTVAL:    rd_data = r_mtval;
            A_MIP:      rd_data = r_mip;
            A_MCYCLE:   rd_data = r_mcycle;
            A_MINSTRET: rd_data = r_minstret;
            A_MHARTID:  rd_data = MHARTID;
            default:    rd_illegal = 1'b1;
        endcase
    end

    assign mstatus_o = r_mstatus;
    assign mtvec_o   = r_mtvec;
    assign mepc_o    = r_mepc;
    assign satp_o    = r_satp;
endmodule

// File: tb/tb_csr_file.sv
// Randomized bench for csr_file: a reference model predicts every cycle's read
// and live outputs, a monitor on the falling edge pops and compares them, and
// directed checks pin the documented corner cases to absolute constants.
module tb_csr_file;
    localparam logic [63:0] HART = 64'd3;
    localparam logic [63:0] MISA = 64'h8000_0000_0000_1100;
    localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

    logic        clk = 1'b0;
    logic        rst;
    logic        wr_en0, wr_en1, wr_en2;
    logic [11:0] wr_addr0, wr_addr1, wr_addr2;
    logic [63:0] wr_data0, wr_data1, wr_data2;
    logic        commit_valid;
    logic [11:0] rd_addr;
    logic [63:0] rd_data;
    logic        rd_illegal;
    logic [63:0] mstatus_o, mtvec_o, mepc_o, satp_o;

    csr_file #(.MHARTID(HART)) dut (
        .clk(clk), .rst(rst),
        .wr_en0(wr_en0), .wr_en1(wr_en1), .wr_en2(wr_en2),
        .wr_addr0(wr_addr0), .wr_addr1(wr_addr1), .wr_addr2(wr_addr2),
        .wr_data0(wr_data0), .wr_data1(wr_data1), .wr_data2(wr_data2),
        .commit_valid(commit_valid), .rd_addr(rd_addr),
        .rd_data(rd_data), .rd_illegal(rd_illegal),
        .mstatus_o(mstatus_o), .mtvec_o(mtvec_o), .mepc_o(mepc_o), .satp_o(satp_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] rd;
        logic        ill;
        logic [63:0] ms, tv, ep, sa;
    } exp_t;

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;

    // Reference model: architectural CSR state keyed by address.
    logic [63:0] m [logic [11:0]];

    function automatic void m_clear();
        m.delete();
        m[12'h180] = '0; m[12'h300] = '0; m[12'h304] = '0; m[12'h305] = '0;
        m[12'h340] = '0; m[12'h341] = '0; m[12'h342] = '0; m[12'h343] = '0;
        m[12'h344] = '0; m[12'hB00] = '0; m[12'hB02] = '0;
    endfunction

    function automatic void m_write(input logic [11:0] a, input logic [63:0] d);
        logic [63:0] o;
        if (!m.exists(a)) return;
        o = m[a];
        case (a)
            12'h300:          m[a] = (o & ~64'h61888) | (d & 64'h61888);
            12'h304, 12'h344: m[a] = (o & ~64'hAAA) | (d & 64'hAAA);
            12'h305:          m[a] = d & ~64'h2;
            12'h341:          m[a] = d & ~64'h3;
            default:          m[a] = d;
        endcase
    endfunction

    // One clock edge out of reset: apply ports in priority order, then counters.
    function automatic void m_step();
        logic [11:0] ad[3];
        logic [63:0] dt[3];
        logic [2:0]  en;
        bit wc = 0, wi = 0;
        ad[0] = wr_addr0; ad[1] = wr_addr1; ad[2] = wr_addr2;
        dt[0] = wr_data0; dt[1] = wr_data1; dt[2] = wr_data2;
        en = {wr_en2, wr_en1, wr_en0};
        for (int k = 0; k < 3; k++) begin
            if (en[k]) begin
                m_write(ad[k], dt[k]);
                if (ad[k] == 12'hB00) wc = 1;
                if (ad[k] == 12'hB02) wi = 1;
            end
        end
        if (!wc) m[12'hB00] = m[12'hB00] + 64'd1;
        if (!wi && commit_valid) m[12'hB02] = m[12'hB02] + 64'd1;
    endfunction

    function automatic void m_read(input logic [11:0] a, output logic [63:0] v, output logic ill);
        ill = 0;
        if (a == 12'h301)      v = MISA;
        else if (a == 12'hF14) v = HART;
        else if (m.exists(a))  v = m[a];
        else begin v = '0; ill = 1; end
    endfunction

    // One bench cycle: model the edge, drive new inputs, predict this cycle's outputs.
    task automatic cyc(input logic rs, input logic cv, input logic [11:0] ra,
                       input logic e0, input logic [11:0] a0, input logic [63:0] d0,
                       input logic e1, input logic [11:0] a1, input logic [63:0] d1,
                       input logic e2, input logic [11:0] a2, input logic [63:0] d2);
        exp_t e;
        @(posedge clk);
        if (!rst) m_step();
        #1;
        rst = rs;
        if (rs) m_clear();
        commit_valid = cv; rd_addr = ra;
        wr_en0 = e0; wr_addr0 = a0; wr_data0 = d0;
        wr_en1 = e1; wr_addr1 = a1; wr_data1 = d1;
        wr_en2 = e2; wr_addr2 = a2; wr_data2 = d2;
        m_read(ra, e.rd, e.ill);
        e.ms = m[12'h300]; e.tv = m[12'h305]; e.ep = m[12'h341]; e.sa = m[12'h180];
        q.push_back(e);
    endtask

    task automatic idle(input logic [11:0] ra);
        cyc(0, 0, ra, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic at_neg();
        @(negedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Monitor: the DUT presents a result every cycle; compare against the oldest prediction.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                checks++;
                if (rd_data !== e.rd || rd_illegal !== e.ill || mstatus_o !== e.ms ||
                    mtvec_o !== e.tv || mepc_o !== e.ep || satp_o !== e.sa) begin
                    errors++;
                    $display("FAIL scoreboard t=%0t addr=%h: rd_data=%h/%h ill=%b/%b mstatus=%h/%h mtvec=%h/%h mepc=%h/%h satp=%h/%h",
                             $time, rd_addr, rd_data, e.rd, rd_illegal, e.ill, mstatus_o, e.ms,
                             mtvec_o, e.tv, mepc_o, e.ep, satp_o, e.sa);
                end
            end
        end
    end

    initial begin
        logic [11:0] pool[16];
        logic [11:0] ra[4];
        logic [63:0] rd[3];
        logic [2:0]  re;
        pool = '{12'h180, 12'h300, 12'h301, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342,
                 12'h343, 12'h344, 12'hB00, 12'hB02, 12'hF14, 12'h7C0, 12'h000, 12'hFFF};
        m_clear();
        rst = 0; commit_valid = 0; rd_addr = 12'hB00;
        wr_en0 = 0; wr_en1 = 0; wr_en2 = 0;
        wr_addr0 = 0; wr_addr1 = 0; wr_addr2 = 0;
        wr_data0 = 0; wr_data1 = 0; wr_data2 = 0;
        #1 rst = 1;

        // Reset state, then release and count five idle cycles.
        cyc(1, 0, 12'hB00, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        at_neg();
        chk("reset_mcycle", rd_data, 64'd0);
        chk("reset_mstatus", mstatus_o, 64'd0);
        idle(12'hB00);
        repeat (5) idle(12'hB00);
        at_neg();
        chk("mcycle_5", rd_data, 64'd5);
        idle(12'h301);
        at_neg();
        chk("misa", rd_data, MISA);
        chk("misa_legal", {63'd0, rd_illegal}, 64'd0);

        // mstatus mask and no read bypass.
        cyc(0, 0, 12'h300, 1, 12'h300, ONES, 0, 0, 0, 0, 0, 0);
        at_neg();
        chk("mstatus_same_cycle", rd_data, 64'd0);
        idle(12'h300);
        at_neg();
        chk("mstatus_masked", mstatus_o, 64'h61888);

        // Same-address priority.
        cyc(0, 0, 12'h341, 1, 12'h341, 64'h1000, 1, 12'h341, 64'h2000, 1, 12'h341, 64'h3003);
        idle(12'h341);
        at_neg();
        chk("mepc_priority", mepc_o, 64'h3000);

        // Different addresses all land.
        cyc(0, 0, 12'h000, 1, 12'h340, 64'h11, 1, 12'h342, 64'h22, 1, 12'h305, 64'h33);
        idle(12'h340);
        at_neg();
        chk("mscratch", rd_data, 64'h11);
        idle(12'h342);
        at_neg();
        chk("mcause", rd_data, 64'h22);
        chk("mtvec", mtvec_o, 64'h31);

        // Counter load and wrap; minstret write beats commit.
        cyc(0, 0, 12'hB00, 1, 12'hB00, ONES, 0, 0, 0, 0, 0, 0);
        idle(12'hB00);
        at_neg();
        chk("mcycle_loaded", rd_data, ONES);
        idle(12'hB00);
        at_neg();
        chk("mcycle_wrap", rd_data, 64'd0);
        cyc(0, 1, 12'hB02, 1, 12'hB02, 64'd7, 0, 0, 0, 0, 0, 0);
        idle(12'hB02);
        at_neg();
        chk("minstret_load", rd_data, 64'd7);
        cyc(0, 1, 12'hB02, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        idle(12'hB02);
        at_neg();
        chk("minstret_commit", rd_data, 64'd8);

        // Unimplemented and read-only addresses.
        cyc(0, 0, 12'h7C0, 1, 12'h7C0, 64'h5, 1, 12'hF14, 64'd0, 1, 12'h301, 64'd0);
        at_neg();
        chk("illegal_flag", {63'd0, rd_illegal}, 64'd1);
        chk("illegal_data", rd_data, 64'd0);
        idle(12'hF14);
        at_neg();
        chk("mhartid", rd_data, HART);
        idle(12'h301);
        at_neg();
        chk("misa_ro", rd_data, MISA);

        // Asynchronous reset mid-cycle, writes ignored while held.
        cyc(1, 1, 12'h301, 1, 12'h300, ONES, 0, 0, 0, 0, 0, 0);
        at_neg();
        chk("async_mstatus", mstatus_o, 64'd0);
        chk("async_mepc", mepc_o, 64'd0);
        chk("async_misa", rd_data, MISA);
        cyc(1, 1, 12'h341, 1, 12'h341, 64'h44, 0, 0, 0, 0, 0, 0);
        idle(12'h341);
        at_neg();
        chk("reset_write_ignored", rd_data, 64'd0);

        // Randomized traffic with address collisions and occasional reset.
        for (int i = 0; i < 600; i++) begin
            for (int k = 0; k < 4; k++) ra[k] = pool[$urandom_range(0, 15)];
            for (int k = 0; k < 3; k++) begin
                case ($urandom_range(0, 3))
                    0:       rd[k] = ONES;
                    1:       rd[k] = 64'd0;
                    default: rd[k] = {$urandom(), $urandom()};
                endcase
            end
            re = 3'($urandom_range(0, 7));
            cyc($urandom_range(0, 99) == 0, 1'($urandom_range(0, 1)), ra[3],
                re[0], ra[0], rd[0], re[1], ra[1], rd[1], re[2], ra[2], rd[2]);
        end
        idle(12'hB00);
        at_neg();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/csr_file.md
CSR_FILE -- requirements
Module: csr_file

Interface
REQ-001 SHALL have parameter MHARTID, default 0, value returned for mhartid (0xF14).
REQ-002 SHALL have port clk  in  1  clock; all state updates on rising edge.
REQ-003 SHALL have port rst  in  1  reset, asynchronous, active-high.
REQ-004 SHALL have ports wr_en0/wr_en1/wr_en2  in  1  CSR write strobes from writeback, ports 0/1/2.
REQ-005 SHALL have ports wr_addr0/wr_addr1/wr_addr2  in  12  CSR write addresses.
REQ-006 SHALL have ports wr_data0/wr_data1/wr_data2  in  64  CSR write values.
REQ-007 SHALL have port commit_valid  in  1  one instruction retired this cycle.
REQ-008 SHALL have port rd_addr  in  12  CSR read address.
REQ-009 SHALL have port rd_data  out  64  read value, combinational from rd_addr.
REQ-010 SHALL have port rd_illegal  out  1  rd_addr not implemented, combinational.
REQ-011 SHALL have ports mstatus_o, mtvec_o, mepc_o, satp_o  out  64 each  live register contents.

Function
REQ-012 SHALL implement: satp 0x180, mstatus 0x300, misa 0x301, mie 0x304, mtvec 0x305, mscratch 0x340, mepc 0x341, mcause 0x342, mtval 0x343, mip 0x344, mcycle 0xB00, minstret 0xB02, mhartid 0xF14.
REQ-013 SHALL return misa as constant 0x8000_0000_0000_1100 and mhartid as MHARTID; writes to either SHALL be ignored.
REQ-014 SHALL apply write masks: mstatus 0x0000_0000_0006_1888; mie and mip 0x0000_0000_0000_0AAA; mepc bits[1:0] forced 0; mtvec bit 1 forced 0; all other implemented CSRs full 64-bit.
REQ-015 Masked write SHALL be new = (old & ~mask) | (data & mask).
REQ-016 Writes SHALL take effect at the rising edge of the cycle the strobe is high; rd_data SHALL show old value that cycle and new value from the next cycle; no read-bypass.
REQ-017 Multiple strobes, same address, same cycle: port 2 SHALL win over port 1, port 1 over port 0.
REQ-018 Strobes to different addresses in the same cycle SHALL all take effect.
REQ-019 Writes to unimplemented addresses SHALL be ignored without side effect.
REQ-020 mcycle SHALL increment by 1 every cycle out of reset; if written that cycle, the written value SHALL load instead (no increment that cycle).
REQ-021 minstret SHALL increment by 1 when commit_valid=1; if written that cycle, the written value SHALL load and the commit SHALL not be counted.
REQ-022 Counters SHALL wrap 0xFFFF_FFFF_FFFF_FFFF -> 0 with no flag.
REQ-023 A strobe held high for several cycles with identical addr/data SHALL be idempotent, except counters reload each cycle held.
REQ-024 rd_illegal SHALL be 1 and rd_data 0 for any unimplemented rd_addr.

Reset
REQ-025 On rst, all writable CSRs, mcycle and minstret SHALL clear to 0 immediately, independent of clk.
REQ-026 While rst=1, counters SHALL not increment and writes SHALL be ignored.
REQ-027 First mcycle increment SHALL occur at the first rising edge after rst deasserts.

Verification
REQ-028 Reset, idle 5 cycles -> rd_addr 0xB00 reads 5; rd_addr 0x301 reads 0x8000_0000_0000_1100; rd_illegal 0.
REQ-029 wr_en0, addr 0x300, data all-ones -> next cycle mstatus_o = 0x0000_0000_0006_1888; same-cycle rd_data 0.
REQ-030 Same cycle: port0 0x341=0x1000, port1 0x341=0x2000, port2 0x341=0x3003 -> mepc_o = 0x3000.
REQ-031 Same cycle: port0 0x340=0x11, port1 0x342=0x22, port2 0x305=0x33 -> mscratch 0x11, mcause 0x22, mtvec 0x31.
REQ-032 Write mcycle 0xFFFF_FFFF_FFFF_FFFF -> reads that value next cycle, 0 the cycle after; commit_valid with minstret write 7 same cycle -> minstret 7.
REQ-033 rd_addr 0x7C0 -> rd_illegal 1, rd_data 0; write 0x7C0 then assert rst mid-run -> all CSRs 0 asynchronously, misa unchanged.
